io_mailbox_responder: RTL and testbench

//  Responder for the datapath I/O bus: decodes four addresses from BASE_ADDR and serves them.
//  The datapath's bus reads return data from this block, and its bus writes are committed here.
//  - Offset 0: DEPTH-entry byte FIFO mailbox. Write pushes, read pops.
//  - Offset 1: status register.
//  - Offset 2: scratch register, also mirrored on o_leds.
//  - Offset 3: snapshot of i_switches.

---
 rtl/io_mailbox_responder.sv | 192 +++++++++++++++++++
 tb/tb_io_mailbox_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/io_mailbox_responder.sv
// I/O bus responder: four decoded registers at BASE_ADDR.
//   +0 byte FIFO mailbox (write pushes, read pops)
//   +1 status {ovf, full, empty, count[4:0]}
//   +2 scratch register, mirrored on o_leds
//   +3 snapshot of i_switches
// Reads are combinational. Writes and pops are committed after each strobe
// has passed through a two-flop synchroniser and its rising edge has been seen.
module io_mailbox_responder #(
  parameter logic [7:0] BASE_ADDR = 8'h10,
  parameter int         DEPTH     = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ioSelect,
  input  logic [7:0] i_ioAddress,
  input  logic       i_ioNOE,
  input  logic       i_ioNWE,
  input  logic [7:0] i_bus,
  output logic [7:0] o_bus,
  output logic       o_busNOE,
  input  logic [7:0] i_switches,
  output logic [7:0] o_leds
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    count;
  logic          ovf;
  logic [7:0]    scratch;
  logic [7:0]    sw_snap;

  logic          hit;
  logic [1:0]    off;
  logic          full, empty;
  logic [7:0]    head;

  // Strobe synchronisers: meta flop, synced value, previous synced value
  logic          noe_m, noe_s, noe_q;
  logic          nwe_m, nwe_s, nwe_q;
  logic [1:0]    settle;
  logic          noe_arm, nwe_arm;

  logic [1:0]    cmd_off;
  logic [7:0]    cmd_data;
  logic          rd_hit, wr_hit;

  logic          noe_fall, noe_rise, nwe_fall, nwe_rise;
  logic          abort, rd_done, wr_done, push, pop;

  assign hit   = i_ioSelect & (i_ioAddress[7:2] == BASE_ADDR[7:2]);
  assign off   = i_ioAddress[1:0];
  assign full  = (count == 5'(DEPTH));
  assign empty = (count == 5'd0);
  assign head  = empty ? 8'h00 : mem[rd_ptr];

  // A falling edge is only honoured once the strobe has been seen high after
  // reset, so a strobe held low across reset release never starts a command.
  assign noe_fall = noe_arm & noe_q & ~noe_s;
  assign nwe_fall = nwe_arm & nwe_q & ~nwe_s;
  assign noe_rise = ~noe_q & noe_s;
  assign nwe_rise = ~nwe_q & nwe_s;

  // Overlapping strobes or a second falling edge cancel the pending command
  assign abort   = (~noe_s & ~nwe_s) | noe_fall | nwe_fall;
  assign rd_done = (state == RD) & ~abort & noe_rise;
  assign wr_done = (state == WR) & ~abort & nwe_rise;
  assign push    = wr_done & wr_hit & (cmd_off == 2'd0) & ~full;
  assign pop     = rd_done & rd_hit & (cmd_off == 2'd0) & ~empty;

  assign o_leds = scratch;

  // Combinational read mux; bus is driven low-impedance only for a decoded read
  always_comb begin
    o_bus    = 8'h00;
    o_busNOE = 1'b1;
    if (hit & ~i_ioNOE & ~i_reset) begin
      o_busNOE = 1'b0;
      case (off)
        2'd0:    o_bus = head;
        2'd1:    o_bus = {ovf, full, empty, count};
        2'd2:    o_bus = scratch;
        default: o_bus = sw_snap;
      endcase
    end
  end

  // Two-flop strobe synchronisers plus post-reset arming
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      noe_m   <= 1'b1;
      noe_s   <= 1'b1;
      noe_q   <= 1'b1;
      nwe_m   <= 1'b1;
      nwe_s   <= 1'b1;
      nwe_q   <= 1'b1;
      settle  <= 2'b00;
      noe_arm <= 1'b0;
      nwe_arm <= 1'b0;
    end else begin
      noe_m   <= i_ioNOE;
      noe_s   <= noe_m;
      noe_q   <= noe_s;
      nwe_m   <= i_ioNWE;
      nwe_s   <= nwe_m;
      nwe_q   <= nwe_s;
      // settle[1] marks the point where the synced value reflects the pins
      settle  <= {settle[0], 1'b1};
      noe_arm <= noe_arm | (settle[1] & noe_s);
      nwe_arm <= nwe_arm | (settle[1] & nwe_s);
    end
  end

  // Capture offset, data and hit while a synced strobe is low
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cmd_off  <= 2'd0;
      cmd_data <= 8'h00;
      rd_hit   <= 1'b0;
      wr_hit   <= 1'b0;
    end else begin
      if ((~noe_s | ~nwe_s) & hit) begin
        cmd_off  <= off;
        cmd_data <= i_bus;
      end
      if (~noe_s) rd_hit <= hit;
      if (~nwe_s) wr_hit <= hit;
    end
  end

  // FIFO storage; written only on a committed push
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= cmd_data;
  end

  // Commit FSM with FIFO pointers, flags, scratch and switch snapshot
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= 5'd0;
      ovf     <= 1'b0;
      scratch <= 8'h00;
      sw_snap <= 8'h00;
    end else begin
      // Hold the snapshot for the duration of a switch read
      if (!((state == RD) && (cmd_off == 2'd3))) sw_snap <= i_switches;

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 5'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        count  <= count - 5'd1;
      end

      case (state)
        IDLE: begin
          if (noe_s | nwe_s) begin
            if (noe_fall & hit)      state <= RD;
            else if (nwe_fall & hit) state <= WR;
          end
        end
        RD: begin
          if (abort) state <= IDLE;
          else if (noe_rise) begin
            state <= IDLE;
            if (rd_hit && cmd_off == 2'd1) ovf <= 1'b0;
          end
        end
        WR: begin
          if (abort) state <= IDLE;
          else if (nwe_rise) begin
            state <= IDLE;
            if (wr_hit) begin
              if (cmd_off == 2'd0 && full) ovf     <= 1'b1;
              if (cmd_off == 2'd2)         scratch <= cmd_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_mailbox_responder.sv
// Directed bench for io_mailbox_responder: vector table plus hand sequences
// for strobe-to-commit timing, switch freeze and reset during a write.
module tb_io_mailbox_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic [7:0] addr;
  logic       noe;
  logic       nwe;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_noe;
  logic [7:0] sw;
  logic [7:0] leds;

  int n_checks = 0;
  int n_fail   = 0;

  io_mailbox_responder #(.BASE_ADDR(8'h10), .DEPTH(8)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_ioSelect  (sel),
    .i_ioAddress (addr),
    .i_ioNOE     (noe),
    .i_ioNWE     (nwe),
    .i_bus       (bus_in),
    .o_bus       (bus_out),
    .o_busNOE    (bus_noe),
    .i_switches  (sw),
    .o_leds      (leds)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp_bus;
    logic       exp_noe;
  } vec_t;

  vec_t vecs [64];
  int   nvec = 0;

  task automatic add(input logic wr, input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] eb, input logic en);
    vecs[nvec] = '{wr, a, d, eb, en};
    nvec++;
  endtask

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk); sel = 1'b1; addr = a; bus_in = d;
    @(negedge clk); nwe = 1'b0;
    repeat (5) @(negedge clk);
    nwe = 1'b1;
    repeat (5) @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] rb, output logic rn);
    @(negedge clk); sel = 1'b1; addr = a;
    @(negedge clk); noe = 1'b0;
    repeat (5) @(negedge clk);
    rb = bus_out;
    rn = bus_noe;
    noe = 1'b1;
    repeat (5) @(negedge clk);
    sel = 1'b0;
  endtask

  initial begin
    logic [7:0] rb;
    logic       rn;

    rst = 1'b1; sel = 1'b0; addr = 8'h00; noe = 1'b1; nwe = 1'b1;
    bus_in = 8'h00; sw = 8'h00;

    // T1: two pushes, status, two pops, status
    add(1, 8'h10, 8'h11, 8'h00, 1);
    add(1, 8'h10, 8'h22, 8'h00, 1);
    add(0, 8'h11, 8'h00, 8'h02, 0);
    add(0, 8'h10, 8'h00, 8'h11, 0);
    add(0, 8'h10, 8'h00, 8'h22, 0);
    add(0, 8'h11, 8'h00, 8'h20, 0);
    // T2: fill, overflow, ovf clear on status read, drain across wrap
    for (int i = 1; i <= 8; i++) add(1, 8'h10, 8'(i), 8'h00, 1);
    add(0, 8'h11, 8'h00, 8'h48, 0);
    add(1, 8'h10, 8'h09, 8'h00, 1);
    add(0, 8'h11, 8'h00, 8'hC8, 0);
    add(0, 8'h11, 8'h00, 8'h48, 0);
    for (int i = 1; i <= 8; i++) add(0, 8'h10, 8'h00, 8'(i), 0);
    add(0, 8'h11, 8'h00, 8'h20, 0);
    // T3: pop while empty
    add(0, 8'h10, 8'h00, 8'h00, 0);
    add(0, 8'h11, 8'h00, 8'h20, 0);
    // Undecoded and read-only offsets ignore writes
    add(1, 8'h14, 8'h33, 8'h00, 1);
    add(1, 8'h13, 8'h77, 8'h00, 1);
    add(1, 8'h11, 8'hFF, 8'h00, 1);
    add(0, 8'h11, 8'h00, 8'h20, 0);
    add(0, 8'h12, 8'h00, 8'h00, 0);
    add(0, 8'h14, 8'h00, 8'h00, 1);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset bus_noe", {7'd0, bus_noe}, 8'h01);
    check("reset bus", bus_out, 8'h00);
    check("reset leds", leds, 8'h00);

    for (int i = 0; i < nvec; i++) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].addr, vecs[i].data);
      end else begin
        bus_read(vecs[i].addr, rb, rn);
        check($sformatf("vec%0d bus", i), rb, vecs[i].exp_bus);
        check($sformatf("vec%0d noe", i), {7'd0, rn}, {7'd0, vecs[i].exp_noe});
      end
    end

    // T4: scratch write lands on o_leds exactly three clocks after NWE rise
    @(negedge clk); sel = 1'b1; addr = 8'h12; bus_in = 8'hA5;
    @(negedge clk); nwe = 1'b0;
    repeat (5) @(negedge clk);
    nwe = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("leds before commit", leds, 8'h00);
    @(negedge clk);
    check("leds at commit", leds, 8'hA5);
    repeat (3) @(negedge clk);
    sel = 1'b0;
    bus_read(8'h12, rb, rn);
    check("scratch read", rb, 8'hA5);
    // Undecoded read: NOE never asserts
    @(negedge clk); sel = 1'b1; addr = 8'h00;
    @(negedge clk); noe = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("undecoded noe c%0d", i), {7'd0, bus_noe}, 8'h01);
    end
    noe = 1'b1;
    repeat (3) @(negedge clk);
    sel = 1'b0;

    // T5: switch snapshot frozen while the read is in progress
    sw = 8'd42;
    @(negedge clk); sel = 1'b1; addr = 8'h13;
    @(negedge clk); noe = 1'b0;
    repeat (5) @(negedge clk);
    check("switch read", bus_out, 8'h2A);
    sw = 8'h55;
    repeat (3) @(negedge clk);
    check("switch held", bus_out, 8'h2A);
    check("switch held noe", {7'd0, bus_noe}, 8'h00);
    noe = 1'b1;
    repeat (5) @(negedge clk);
    sel = 1'b0;
    bus_read(8'h13, rb, rn);
    check("switch resumed", rb, 8'h55);

    // T6: reset while a FIFO write strobe is low; the strobe must be ignored
    @(negedge clk); sel = 1'b1; addr = 8'h10; bus_in = 8'h99;
    @(negedge clk); nwe = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    nwe = 1'b1;
    repeat (6) @(negedge clk);
    sel = 1'b0;
    check("reset mid-write leds", leds, 8'h00);
    bus_read(8'h11, rb, rn);
    check("reset mid-write status", rb, 8'h20);
    bus_write(8'h10, 8'h5A);
    bus_read(8'h11, rb, rn);
    check("post-reset status", rb, 8'h01);
    bus_read(8'h10, rb, rn);
    check("post-reset pop", rb, 8'h5A);
    bus_read(8'h11, rb, rn);
    check("post-reset empty", rb, 8'h20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
